iob_pcie_chnl_host: RTL and testbench

Host-side end of the PCIe user-channel protocol. It drives the CHNL_RX* signals towards a channel user block and consumes that block's CHNL_TX* transfers. Commands and outbound data come from a streaming source; inbound data goes to a streaming sink. The block serves as a channel bridge inside the PCIe wrapper and as a synthesizable stimulus/checker for channel user logic in simulation.

---
 rtl/iob_pcie_chnl_pkg.sv | 26 ++
 rtl/iob_pcie_chnl_host_if.sv | 64 ++++++
 rtl/iob_pcie_chnl_beat_cnt.sv | 34 +++
 rtl/iob_pcie_chnl_host.sv | 195 +++++++++++++++++++
 tb/tb_iob_pcie_chnl_host.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/iob_pcie_chnl_pkg.sv
// Shared encodings and widths for the host end of the PCIe user channel.
package iob_pcie_chnl_pkg;

    localparam int LEN_W      = 32;
    localparam int OFF_W      = 31;
    localparam int CNT_W      = LEN_W + 1;
    localparam int DEF_DATA_W = 64;
    localparam int BEAT_WORDS = DEF_DATA_W / 32;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_REQ  = 2'd1,
        RX_DATA = 2'd2
    } rxState_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ACK  = 2'd1,
        TX_DATA = 2'd2
    } txState_t;

    function automatic int beatWords(input int dataW);
        return dataW / 32;
    endfunction

endpackage

// File: rtl/iob_pcie_chnl_host_if.sv
// Command/stream side and CHNL_RX*/CHNL_TX* side of the host channel bridge.
interface iob_pcie_chnl_host_if #(
    parameter int C_PCI_DATA_WIDTH = 64
);
    import iob_pcie_chnl_pkg::*;

    logic                        CMD_VALID;
    logic                        CMD_READY;
    logic [LEN_W-1:0]            CMD_LEN;
    logic [OFF_W-1:0]            CMD_OFF;
    logic                        CMD_LAST;
    logic [C_PCI_DATA_WIDTH-1:0] SRC_DATA;
    logic                        SRC_VALID;
    logic                        SRC_READY;
    logic [C_PCI_DATA_WIDTH-1:0] SNK_DATA;
    logic                        SNK_VALID;
    logic                        SNK_READY;
    logic                        SNK_LAST;
    logic [LEN_W-1:0]            TX_INFO_LEN;
    logic [OFF_W-1:0]            TX_INFO_OFF;
    logic                        TX_INFO_LAST;
    logic                        RX_DONE;
    logic                        TX_DONE;
    logic                        ERR_TIMEOUT;

    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [LEN_W-1:0]            CHNL_RX_LEN;
    logic [OFF_W-1:0]            CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;

    logic                        CHNL_TX;
    logic                        CHNL_TX_ACK;
    logic                        CHNL_TX_LAST;
    logic [LEN_W-1:0]            CHNL_TX_LEN;
    logic [OFF_W-1:0]            CHNL_TX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
    logic                        CHNL_TX_DATA_VALID;
    logic                        CHNL_TX_DATA_REN;

    modport master (
        input  CMD_VALID, CMD_LEN, CMD_OFF, CMD_LAST, SRC_DATA, SRC_VALID, SNK_READY,
        input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        output CMD_READY, SRC_READY, SNK_DATA, SNK_VALID, SNK_LAST,
        output TX_INFO_LEN, TX_INFO_OFF, TX_INFO_LAST, RX_DONE, TX_DONE, ERR_TIMEOUT,
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN
    );

    modport slave (
        output CMD_VALID, CMD_LEN, CMD_OFF, CMD_LAST, SRC_DATA, SRC_VALID, SNK_READY,
        output CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        input  CMD_READY, SRC_READY, SNK_DATA, SNK_VALID, SNK_LAST,
        input  TX_INFO_LEN, TX_INFO_OFF, TX_INFO_LAST, RX_DONE, TX_DONE, ERR_TIMEOUT,
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN
    );

endinterface

// File: rtl/iob_pcie_chnl_beat_cnt.sv
// Transfer word counter: 33 bits so a length near 2^32 cannot wrap.
module iob_pcie_chnl_beat_cnt
    import iob_pcie_chnl_pkg::*;
#(
    parameter int BEAT_W = BEAT_WORDS
) (
    input  logic             PCIE_CLK,
    input  logic             PCIE_RST,
    input  logic             clr,
    input  logic             add,
    input  logic [LEN_W-1:0] len,
    output logic             geLen,
    output logic             lastBeat
);

    logic [CNT_W-1:0] wordCnt;
    logic [CNT_W:0]   nextSum;

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            wordCnt <= '0;
        end else if (clr) begin
            wordCnt <= '0;
        end else if (add) begin
            wordCnt <= wordCnt + CNT_W'(BEAT_W);
        end
    end

    // lastBeat looks one beat ahead: true when the beat now on offer finishes the length.
    assign nextSum  = {1'b0, wordCnt} + (CNT_W + 1)'(BEAT_W);
    assign geLen    = wordCnt >= CNT_W'(len);
    assign lastBeat = nextSum >= (CNT_W + 1)'(len);

endmodule

// File: rtl/iob_pcie_chnl_host.sv
// Host end of the PCIe user channel: RX FSM drives CHNL_RX* from commands and
// the source stream, TX FSM accepts CHNL_TX* transfers into the sink stream.
//
// state   | meaning
// RX_IDLE | CMD_READY high, waiting for a command
// RX_REQ  | CHNL_RX high, waiting for CHNL_RX_ACK (timed)
// RX_DATA | moving source beats until the word count covers LEN
// TX_IDLE | waiting for CHNL_TX, captures TX_INFO_*
// TX_ACK  | CHNL_TX_ACK for one cycle
// TX_DATA | moving channel beats to the sink until the last beat
module iob_pcie_chnl_host
    import iob_pcie_chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int TIMEOUT_W        = 16
) (
    input logic                   PCIE_CLK,
    input logic                   PCIE_RST,
    iob_pcie_chnl_host_if.master  bus
);

    localparam int BW = beatWords(C_PCI_DATA_WIDTH);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

    rxState_t             rxState, rxNext;
    logic                 rxCapture, rxFinish, rxTmo, rxTmrRun;
    logic                 rxWin, rxBeat, rxGe;
    logic [TIMEOUT_W-1:0] rxTmr;
    logic [LEN_W-1:0]     rxLen;
    logic [OFF_W-1:0]     rxOff;
    logic                 rxLast, rxDone, errTmo;

    txState_t             txState, txNext;
    logic                 txCapture, txFinish;
    logic                 txWin, txBeat, txGe, txLastBeat;
    logic [LEN_W-1:0]     txLen;
    logic [OFF_W-1:0]     txOff;
    logic                 txLast, txDone;

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            rxState <= RX_IDLE;
            txState <= TX_IDLE;
        end else begin
            rxState <= rxNext;
            txState <= txNext;
        end
    end

    // The ACK timer is one short of its limit so the flag rises after 2^W-1 REQ cycles.
    always_comb begin
        rxNext    = rxState;
        rxCapture = 1'b0;
        rxFinish  = 1'b0;
        rxTmo     = 1'b0;
        rxTmrRun  = 1'b0;
        unique case (rxState)
            RX_IDLE: begin
                if (bus.CMD_VALID) begin
                    rxCapture = 1'b1;
                    rxNext    = RX_REQ;
                end
            end
            RX_REQ: begin
                if (bus.CHNL_RX_ACK) begin
                    rxNext = RX_DATA;
                end else if (rxTmr == TMO_LAST) begin
                    rxTmo  = 1'b1;
                    rxNext = RX_IDLE;
                end else begin
                    rxTmrRun = 1'b1;
                end
            end
            RX_DATA: begin
                if (rxGe) begin
                    rxFinish = 1'b1;
                    rxNext   = RX_IDLE;
                end
            end
            default: rxNext = RX_IDLE;
        endcase
    end

    always_comb begin
        txNext    = txState;
        txCapture = 1'b0;
        txFinish  = 1'b0;
        unique case (txState)
            TX_IDLE: begin
                if (bus.CHNL_TX) begin
                    txCapture = 1'b1;
                    txNext    = TX_ACK;
                end
            end
            TX_ACK: begin
                // Counter was cleared at capture, so geLen here means LEN == 0.
                if (txGe) begin
                    txFinish = 1'b1;
                    txNext   = TX_IDLE;
                end else begin
                    txNext = TX_DATA;
                end
            end
            TX_DATA: begin
                if ((txBeat && txLastBeat) || !bus.CHNL_TX) begin
                    txFinish = 1'b1;
                    txNext   = TX_IDLE;
                end
            end
            default: txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            rxLen  <= '0;
            rxOff  <= '0;
            rxLast <= 1'b0;
            rxTmr  <= '0;
            rxDone <= 1'b0;
            errTmo <= 1'b0;
            txLen  <= '0;
            txOff  <= '0;
            txLast <= 1'b0;
            txDone <= 1'b0;
        end else begin
            rxDone <= rxFinish;
            txDone <= txFinish;
            if (rxTmo) begin
                errTmo <= 1'b1;
            end
            if (rxCapture) begin
                rxLen  <= bus.CMD_LEN;
                rxOff  <= bus.CMD_OFF;
                rxLast <= bus.CMD_LAST;
                rxTmr  <= '0;
            end else if (rxTmrRun) begin
                rxTmr <= rxTmr + TIMEOUT_W'(1);
            end
            if (txCapture) begin
                txLen  <= bus.CHNL_TX_LEN;
                txOff  <= bus.CHNL_TX_OFF;
                txLast <= bus.CHNL_TX_LAST;
            end
        end
    end

    iob_pcie_chnl_beat_cnt #(.BEAT_W(BW)) u_rx_cnt (
        .PCIE_CLK (PCIE_CLK),
        .PCIE_RST (PCIE_RST),
        .clr      (rxCapture),
        .add      (rxBeat),
        .len      (rxLen),
        .geLen    (rxGe),
        .lastBeat ()
    );

    iob_pcie_chnl_beat_cnt #(.BEAT_W(BW)) u_tx_cnt (
        .PCIE_CLK (PCIE_CLK),
        .PCIE_RST (PCIE_RST),
        .clr      (txCapture),
        .add      (txBeat),
        .len      (txLen),
        .geLen    (txGe),
        .lastBeat (txLastBeat)
    );

    // RX window closes once the count covers LEN, so the closing cycle moves no data.
    assign rxWin  = (rxState == RX_DATA) && !rxGe;
    assign rxBeat = bus.CHNL_RX_DATA_VALID && bus.CHNL_RX_DATA_REN;
    assign txWin  = (txState == TX_DATA);
    assign txBeat = bus.SNK_VALID && bus.CHNL_TX_DATA_REN;

    assign bus.CMD_READY          = (rxState == RX_IDLE);
    assign bus.CHNL_RX            = (rxState != RX_IDLE);
    assign bus.CHNL_RX_LEN        = rxLen;
    assign bus.CHNL_RX_OFF        = rxOff;
    assign bus.CHNL_RX_LAST       = rxLast;
    assign bus.CHNL_RX_DATA       = rxWin ? bus.SRC_DATA : '0;
    assign bus.CHNL_RX_DATA_VALID = rxWin && bus.SRC_VALID;
    assign bus.SRC_READY          = rxWin && bus.CHNL_RX_DATA_REN;
    assign bus.RX_DONE            = rxDone;
    assign bus.ERR_TIMEOUT        = errTmo;

    assign bus.CHNL_TX_ACK      = (txState == TX_ACK);
    assign bus.SNK_DATA         = txWin ? bus.CHNL_TX_DATA : '0;
    assign bus.SNK_VALID        = txWin && bus.CHNL_TX_DATA_VALID;
    assign bus.CHNL_TX_DATA_REN = txWin && bus.SNK_READY;
    assign bus.SNK_LAST         = bus.SNK_VALID && txLastBeat;
    assign bus.TX_INFO_LEN      = txLen;
    assign bus.TX_INFO_OFF      = txOff;
    assign bus.TX_INFO_LAST     = txLast;
    assign bus.TX_DONE          = txDone;

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Directed vector bench for iob_pcie_chnl_host (64-bit data, 4-bit ACK timer).
module tb_iob_pcie_chnl_host;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nVec  = 0;
    int   nMiss = 0;

    iob_pcie_chnl_host_if #(.C_PCI_DATA_WIDTH(DW)) bus ();

    iob_pcie_chnl_host #(.C_PCI_DATA_WIDTH(DW), .TIMEOUT_W(4)) dut (
        .PCIE_CLK (clk),
        .PCIE_RST (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // in : cmdValid ack srcValid ren chnlTx txValid snkReady
    // exp: cmdReady chnlRx rxValid srcReady rxDone txAck snkValid txRen snkLast txDone err
    typedef struct {
        string       name;
        logic [6:0]  in;
        logic [31:0] len;
        logic [10:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input string n, input logic [6:0] i, input logic [31:0] l,
                                input logic [10:0] e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.len  = l;
        v.exp  = e;
        tv.push_back(v);
    endfunction

    function automatic logic [10:0] flags();
        return {bus.CMD_READY, bus.CHNL_RX, bus.CHNL_RX_DATA_VALID, bus.SRC_READY, bus.RX_DONE,
                bus.CHNL_TX_ACK, bus.SNK_VALID, bus.CHNL_TX_DATA_REN, bus.SNK_LAST, bus.TX_DONE,
                bus.ERR_TIMEOUT};
    endfunction

    function automatic logic [11:0] allFlags();
        return {bus.CMD_READY, bus.SRC_READY, bus.SNK_VALID, bus.SNK_LAST, bus.RX_DONE,
                bus.TX_DONE, bus.ERR_TIMEOUT, bus.CHNL_RX, bus.CHNL_RX_LAST,
                bus.CHNL_RX_DATA_VALID, bus.CHNL_TX_ACK, bus.CHNL_TX_DATA_REN};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] i, input logic [31:0] l);
        {bus.CMD_VALID, bus.CHNL_RX_ACK, bus.SRC_VALID, bus.CHNL_RX_DATA_REN,
         bus.CHNL_TX, bus.CHNL_TX_DATA_VALID, bus.SNK_READY} = i;
        bus.CMD_LEN      = l;
        bus.CHNL_TX_LEN  = l;
        bus.SRC_DATA     = {$urandom, $urandom};
        bus.CHNL_TX_DATA = {$urandom, $urandom};
    endtask

    initial begin
        int  beats;
        bit  seen;

        bus.CMD_OFF      = 31'h1234;
        bus.CMD_LAST     = 1'b1;
        bus.CHNL_TX_OFF  = 31'd5;
        bus.CHNL_TX_LAST = 1'b1;
        drive(7'b0000000, 32'd0);

        add("rx4 cmd",   7'b1000000, 32'd4, 11'b10000000000);
        add("rx4 req1",  7'b0011000, 32'd4, 11'b01000000000);
        add("rx4 req2",  7'b0011000, 32'd4, 11'b01000000000);
        add("rx4 ack",   7'b0111000, 32'd4, 11'b01000000000);
        add("rx4 beat1", 7'b0011000, 32'd4, 11'b01110000000);
        add("rx4 beat2", 7'b0011000, 32'd4, 11'b01110000000);
        add("rx4 close", 7'b0011000, 32'd4, 11'b01000000000);
        add("rx4 done",  7'b0000000, 32'd4, 11'b10001000000);
        add("rx4 idle",  7'b0000000, 32'd4, 11'b10000000000);
        add("rx3 cmd",   7'b1000000, 32'd3, 11'b10000000000);
        add("rx3 ack",   7'b0100000, 32'd3, 11'b01000000000);
        add("rx3 ren1",  7'b0011000, 32'd3, 11'b01110000000);
        add("rx3 ren0",  7'b0010000, 32'd3, 11'b01100000000);
        add("rx3 ren1b", 7'b0011000, 32'd3, 11'b01110000000);
        add("rx3 close", 7'b0010000, 32'd3, 11'b01000000000);
        add("rx3 done",  7'b0000000, 32'd3, 11'b10001000000);
        add("rx0 cmd",   7'b1000000, 32'd0, 11'b10000000000);
        add("rx0 ack",   7'b0100000, 32'd0, 11'b01000000000);
        add("rx0 close", 7'b0011000, 32'd0, 11'b01000000000);
        add("rx0 done",  7'b0000000, 32'd0, 11'b10001000000);
        add("tx6 req",   7'b0000100, 32'd6, 11'b10000000000);
        add("tx6 ack",   7'b0000100, 32'd6, 11'b10000100000);
        add("tx6 rdy1",  7'b0000111, 32'd6, 11'b10000011000);
        add("tx6 rdy0",  7'b0000110, 32'd6, 11'b10000010000);
        add("tx6 rdy1b", 7'b0000111, 32'd6, 11'b10000011000);
        add("tx6 last",  7'b0000111, 32'd6, 11'b10000011100);
        add("tx6 done",  7'b0000000, 32'd6, 11'b10000000010);
        add("tx6 idle",  7'b0000000, 32'd6, 11'b10000000000);
        add("txe req",   7'b0000100, 32'd8, 11'b10000000000);
        add("txe ack",   7'b0000100, 32'd8, 11'b10000100000);
        add("txe beat",  7'b0000111, 32'd8, 11'b10000011000);
        add("txe drop",  7'b0000001, 32'd8, 11'b10000001000);
        add("txe done",  7'b0000000, 32'd8, 11'b10000000010);
        add("tx0 req",   7'b0000100, 32'd0, 11'b10000000000);
        add("tx0 ack",   7'b0000000, 32'd0, 11'b10000100000);
        add("tx0 done",  7'b0000000, 32'd0, 11'b10000000010);
        add("tx0 idle",  7'b0000000, 32'd0, 11'b10000000000);

        repeat (2) @(negedge clk);
        check("reset flags", {52'd0, allFlags()}, 64'h800);
        check("reset rx len", {32'd0, bus.CHNL_RX_LEN}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].in, tv[i].len);
            #2;
            check(tv[i].name, {53'd0, flags()}, {53'd0, tv[i].exp});
            if (tv[i].exp[8]) check({tv[i].name, " rxdata"}, bus.CHNL_RX_DATA, bus.SRC_DATA);
            if (tv[i].exp[4]) check({tv[i].name, " snkdata"}, bus.SNK_DATA, bus.CHNL_TX_DATA);
        end

        // ACK never arrives: flag rises after 15 REQ cycles and stays set.
        @(negedge clk);
        drive(7'b1000000, 32'd2);
        @(negedge clk);
        drive(7'b0000000, 32'd2);
        repeat (14) @(negedge clk);
        #2;
        check("tmo pre", {62'd0, bus.ERR_TIMEOUT, bus.CHNL_RX}, 64'b01);
        @(negedge clk);
        #2;
        check("tmo hit", {61'd0, bus.ERR_TIMEOUT, bus.CHNL_RX, bus.CMD_READY}, 64'b101);
        repeat (4) @(negedge clk);
        check("tmo sticky", {63'd0, bus.ERR_TIMEOUT}, 64'd1);

        // RX and TX both mid-transfer when reset hits.
        @(negedge clk);
        drive(7'b1000100, 32'd4);
        bus.CHNL_TX_LEN = 32'd6;
        @(negedge clk);
        drive(7'b0100100, 32'd4);
        bus.CHNL_TX_LEN = 32'd6;
        #2;
        check("rx fields", {bus.CHNL_RX_LEN, bus.CHNL_RX_OFF, bus.CHNL_RX_LAST},
              {32'd4, 31'h1234, 1'b1});
        check("tx info", {bus.TX_INFO_LEN, bus.TX_INFO_OFF, bus.TX_INFO_LAST},
              {32'd6, 31'd5, 1'b1});
        check("tx ack", {63'd0, bus.CHNL_TX_ACK}, 64'd1);
        @(negedge clk);
        drive(7'b0011101, 32'd4);
        #2;
        check("rx beat data", bus.CHNL_RX_DATA, bus.SRC_DATA);
        check("tx ack once", {63'd0, bus.CHNL_TX_ACK}, 64'd0);
        @(negedge clk);
        drive(7'b0010110, 32'd4);
        #1;
        rst = 1'b1;
        #1;
        check("reset outputs", {52'd0, allFlags()}, 64'h800);
        check("reset buses", bus.CHNL_RX_DATA | bus.SNK_DATA, 64'd0);
        check("reset tx info", {32'd0, bus.TX_INFO_LEN}, 64'd0);
        drive(7'b0000000, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("no done in reset", {62'd0, bus.RX_DONE, bus.TX_DONE}, 64'd0);
        end
        rst = 1'b0;

        @(negedge clk);
        drive(7'b1000000, 32'd2);
        beats = 0;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            drive(7'b0111000, 32'd2);
            #2;
            if (bus.CHNL_RX_DATA_VALID && bus.SRC_READY) beats++;
            if (bus.RX_DONE) seen = 1'b1;
        end
        check("post-reset done", {63'd0, seen}, 64'd1);
        check("post-reset beats", 64'(beats), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
